// File: rtl/mem_arb_pkg.sv
// Shared types and size encodings for the instruction/data memory port arbiter
// and the load/store alignment checker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch side, the load/store side and the memory side of the shared port.
// master is the arbiter's view; slave is the core plus memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [2:0]        data_size_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [31:0]       data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [2:0]        mem_size_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wd_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rd_i;

  modport master (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_size_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wd_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rd_i
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_size_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wd_o,
    output mem_gnt_i, mem_rvalid_i, mem_rd_i
  );

endinterface

// File: rtl/mem_align_check.sv
// Flags a load/store whose size code is illegal or whose byte address is not
// naturally aligned for that size. Purely combinational.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  // size decode: bytes never misalign, halves need addr[0]=0, words need addr[1:0]=0
  always_comb begin
    misaligned = 1'b1;
    case (size)
      SZ_B, SZ_BU: misaligned = 1'b0;
      SZ_H, SZ_HU: misaligned = addr_lo[0];
      SZ_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first,
// with an anti-starvation counter and local rejection of misaligned data accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.master bus
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_r;
  arb_state_e        state_s;
  owner_e            owner_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [2:0]        mem_size_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wd_r;

  logic misaligned_s;
  logic data_win_s;
  logic instr_win_s;
  logic resp_s;
  logic instr_rvalid_s;
  logic data_rvalid_s;
  logic data_resp_s;

  mem_align_check u_align (
    .size       (bus.data_size_i),
    .addr_lo    (bus.data_addr_i[1:0]),
    .misaligned (misaligned_s)
  );

  // arbitration in IDLE; gated by reset so no grant leaks out while held in reset
  always_comb begin
    data_win_s  = 1'b0;
    instr_win_s = 1'b0;
    if (rst_i && (state_r == IDLE)) begin
      data_win_s  = bus.data_req_i && !(bus.instr_req_i && (starve_cnt_r == LIMIT_C));
      instr_win_s = bus.instr_req_i && !data_win_s;
    end else begin
      data_win_s  = 1'b0;
      instr_win_s = 1'b0;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (data_win_s)       state_s = misaligned_s ? ERR : REQ;
        else if (instr_win_s) state_s = REQ;
        else                  state_s = IDLE;
      end
      REQ: begin
        if (bus.mem_gnt_i) state_s = bus.mem_rvalid_i ? IDLE : WAIT;
        else               state_s = REQ;
      end
      WAIT: begin
        if (bus.mem_rvalid_i) state_s = IDLE;
        else                  state_s = WAIT;
      end
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // owner and memory-request capture; attributes hold until the memory grants
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_r    <= INSTR;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_size_r <= 3'd0;
      mem_addr_r <= '0;
      mem_wd_r   <= 32'd0;
    end else if (data_win_s) begin
      owner_r <= DATA;
      if (!misaligned_s) begin
        mem_req_r  <= 1'b1;
        mem_we_r   <= bus.data_we_i;
        mem_size_r <= bus.data_size_i;
        mem_addr_r <= bus.data_addr_i;
        mem_wd_r   <= bus.data_wdata_i;
      end
    end else if (instr_win_s) begin
      owner_r    <= INSTR;
      mem_req_r  <= 1'b1;
      mem_we_r   <= 1'b0;
      mem_size_r <= SZ_W;
      mem_addr_r <= bus.instr_addr_i;
      mem_wd_r   <= 32'd0;
    end else if ((state_r == REQ) && bus.mem_gnt_i) begin
      mem_req_r <= 1'b0;
    end
  end

  // consecutive data grants taken while a fetch was waiting
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_r <= '0;
    end else if (data_win_s) begin
      if (!bus.instr_req_i)              starve_cnt_r <= '0;
      else if (starve_cnt_r != LIMIT_C)  starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else if (instr_win_s) begin
      starve_cnt_r <= '0;
    end
  end

  assign resp_s = ((state_r == REQ) && bus.mem_gnt_i && bus.mem_rvalid_i) ||
                  ((state_r == WAIT) && bus.mem_rvalid_i);

  assign instr_rvalid_s = resp_s && (owner_r == INSTR);
  assign data_resp_s    = resp_s && (owner_r == DATA);
  assign data_rvalid_s  = data_resp_s || (state_r == ERR);

  assign bus.instr_gnt_o    = instr_win_s;
  assign bus.instr_rvalid_o = instr_rvalid_s;
  assign bus.instr_rdata_o  = instr_rvalid_s ? bus.mem_rd_i : 32'd0;

  assign bus.data_gnt_o    = data_win_s;
  assign bus.data_rvalid_o = data_rvalid_s;
  assign bus.data_rdata_o  = data_resp_s ? bus.mem_rd_i : 32'd0;
  assign bus.data_err_o    = (state_r == ERR);

  assign bus.mem_req_o  = mem_req_r;
  assign bus.mem_we_o   = mem_we_r;
  assign bus.mem_size_o = mem_size_r;
  assign bus.mem_addr_o = mem_addr_r;
  assign bus.mem_wd_o   = mem_wd_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// starvation and mid-transaction reset sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // in_f = {instr_req, data_req, data_we, mem_gnt, mem_rvalid}
  // ex_f = {instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err, mem_req, mem_we}
  typedef struct {
    string       name;
    logic [4:0]  in_f;
    logic [31:0] iaddr;
    logic [2:0]  dsz;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [31:0] mrd;
    logic [6:0]  ex_f;
    logic [31:0] ird;
    logic [31:0] drd;
    logic [2:0]  msz;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [4:0] in_f, logic [31:0] iaddr, logic [2:0] dsz,
                              logic [31:0] daddr, logic [31:0] dwd, logic [31:0] mrd, logic [6:0] ex_f,
                              logic [31:0] ird, logic [31:0] drd, logic [2:0] msz, logic [31:0] maddr,
                              logic [31:0] mwd);
    vec_t v;
    v.name = nm; v.in_f = in_f; v.iaddr = iaddr; v.dsz = dsz; v.daddr = daddr; v.dwd = dwd;
    v.mrd = mrd; v.ex_f = ex_f; v.ird = ird; v.drd = drd; v.msz = msz; v.maddr = maddr; v.mwd = mwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in_f, input logic [31:0] iaddr, input logic [2:0] dsz,
                       input logic [31:0] daddr, input logic [31:0] dwd, input logic [31:0] mrd);
    bus.instr_req_i  = in_f[4];
    bus.instr_addr_i = iaddr;
    bus.data_req_i   = in_f[3];
    bus.data_we_i    = in_f[2];
    bus.data_size_i  = dsz;
    bus.data_addr_i  = daddr;
    bus.data_wdata_i = dwd;
    bus.mem_gnt_i    = in_f[1];
    bus.mem_rvalid_i = in_f[0];
    bus.mem_rd_i     = mrd;
  endtask

  // Inputs are applied just after a rising edge, outputs checked on the falling edge.
  task automatic apply(input vec_t v);
    drive(v.in_f, v.iaddr, v.dsz, v.daddr, v.dwd, v.mrd);
    @(negedge clk_i);
    chk({v.name, " instr_gnt"},    32'(bus.instr_gnt_o),    32'(v.ex_f[6]));
    chk({v.name, " instr_rvalid"}, 32'(bus.instr_rvalid_o), 32'(v.ex_f[5]));
    chk({v.name, " instr_rdata"},  bus.instr_rdata_o,       v.ird);
    chk({v.name, " data_gnt"},     32'(bus.data_gnt_o),     32'(v.ex_f[4]));
    chk({v.name, " data_rvalid"},  32'(bus.data_rvalid_o),  32'(v.ex_f[3]));
    chk({v.name, " data_err"},     32'(bus.data_err_o),     32'(v.ex_f[2]));
    chk({v.name, " data_rdata"},   bus.data_rdata_o,        v.drd);
    chk({v.name, " mem_req"},      32'(bus.mem_req_o),      32'(v.ex_f[1]));
    if (v.ex_f[1]) begin
      chk({v.name, " mem_addr"}, bus.mem_addr_o,      v.maddr);
      chk({v.name, " mem_we"},   32'(bus.mem_we_o),   32'(v.ex_f[0]));
      chk({v.name, " mem_size"}, 32'(bus.mem_size_o), 32'(v.msz));
      if (v.ex_f[0]) chk({v.name, " mem_wd"}, bus.mem_wd_o, v.mwd);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " instr_gnt"},    32'(bus.instr_gnt_o),    32'd0);
    chk({nm, " instr_rvalid"}, 32'(bus.instr_rvalid_o), 32'd0);
    chk({nm, " instr_rdata"},  bus.instr_rdata_o,       32'd0);
    chk({nm, " data_gnt"},     32'(bus.data_gnt_o),     32'd0);
    chk({nm, " data_rvalid"},  32'(bus.data_rvalid_o),  32'd0);
    chk({nm, " data_rdata"},   bus.data_rdata_o,        32'd0);
    chk({nm, " data_err"},     32'(bus.data_err_o),     32'd0);
    chk({nm, " mem_req"},      32'(bus.mem_req_o),      32'd0);
    chk({nm, " mem_we"},       32'(bus.mem_we_o),       32'd0);
    chk({nm, " mem_size"},     32'(bus.mem_size_o),     32'd0);
    chk({nm, " mem_addr"},     bus.mem_addr_o,          32'd0);
    chk({nm, " mem_wd"},       bus.mem_wd_o,            32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte  gq[$];
    logic [7:0] exp_g [7];
    logic [7:0] got_g;
    int   dleft;
    logic ipend;

    // fetch only
    vecs.push_back(mk("fetch_c0", 5'b10000, 32'h100, SZ_B, 32'h0, 32'h0, 32'h0, 7'b1000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("fetch_c1", 5'b00010, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000010, 32'h0, 32'h0, SZ_W, 32'h100, 32'h0));
    vecs.push_back(mk("fetch_c2", 5'b00001, 32'h0, SZ_B, 32'h0, 32'h0, 32'h00500093, 7'b0100000, 32'h00500093, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("fetch_c3", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    // simultaneous requests: data first, fetch after data completes (immediate mem response)
    vecs.push_back(mk("simul_c0", 5'b11000, 32'h104, SZ_W, 32'h2000, 32'h0, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("simul_c1", 5'b10010, 32'h104, SZ_W, 32'h0, 32'h0, 32'h0, 7'b0000010, 32'h0, 32'h0, SZ_W, 32'h2000, 32'h0));
    vecs.push_back(mk("simul_c2", 5'b10001, 32'h104, SZ_B, 32'h0, 32'h0, 32'hCAFEF00D, 7'b0001000, 32'h0, 32'hCAFEF00D, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("simul_c3", 5'b10000, 32'h104, SZ_B, 32'h0, 32'h0, 32'h0, 7'b1000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("simul_c4", 5'b00011, 32'h0, SZ_B, 32'h0, 32'h0, 32'h11111111, 7'b0100010, 32'h11111111, 32'h0, SZ_W, 32'h104, 32'h0));
    vecs.push_back(mk("simul_c5", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    // misaligned / illegal rejected locally, aligned forwarded
    vecs.push_back(mk("mis_w2002_g", 5'b01000, 32'h0, SZ_W, 32'h2002, 32'h0, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("mis_w2002_e", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0001100, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("mis_h2003_g", 5'b01000, 32'h0, SZ_H, 32'h2003, 32'h0, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("mis_h2003_e", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0001100, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("ok_h2002_g", 5'b01000, 32'h0, SZ_H, 32'h2002, 32'h0, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("ok_h2002_r", 5'b00011, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0000BEEF, 7'b0001010, 32'h0, 32'h0000BEEF, SZ_H, 32'h2002, 32'h0));
    vecs.push_back(mk("ill_sz3_g", 5'b01000, 32'h0, 3'd3, 32'h2000, 32'h0, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("ill_sz3_e", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0001100, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("ok_bu2003_g", 5'b01000, 32'h0, SZ_BU, 32'h2003, 32'h0, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("ok_bu2003_r", 5'b00011, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0000007F, 7'b0001010, 32'h0, 32'h0000007F, SZ_BU, 32'h2003, 32'h0));
    // store with memory grant delayed three cycles
    vecs.push_back(mk("sw_g", 5'b01100, 32'h0, SZ_W, 32'h3000, 32'hDEADBEEF, 32'h0, 7'b0010000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("sw_wait1", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000011, 32'h0, 32'h0, SZ_W, 32'h3000, 32'hDEADBEEF));
    vecs.push_back(mk("sw_wait2", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000011, 32'h0, 32'h0, SZ_W, 32'h3000, 32'hDEADBEEF));
    vecs.push_back(mk("sw_wait3", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000011, 32'h0, 32'h0, SZ_W, 32'h3000, 32'hDEADBEEF));
    vecs.push_back(mk("sw_mgnt", 5'b00010, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000011, 32'h0, 32'h0, SZ_W, 32'h3000, 32'hDEADBEEF));
    vecs.push_back(mk("sw_resp", 5'b00001, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0001000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    vecs.push_back(mk("sw_idle", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));

    // reset held with both requesters active: nothing may leak out
    drive(5'b11000, 32'h100, SZ_W, 32'h2000, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // starvation: six loads back to back against a waiting fetch
    exp_g = '{"D", "D", "D", "D", "I", "D", "D"};
    dleft = 6;
    ipend = 1'b1;
    for (int cyc = 0; cyc < 60 && gq.size() < 7; cyc++) begin
      drive({ipend, (dleft > 0), 1'b0, bus.mem_req_o, bus.mem_req_o}, 32'h200, SZ_W, 32'h4000, 32'h0, 32'h0);
      @(negedge clk_i);
      if (bus.data_gnt_o) begin
        gq.push_back("D");
        dleft--;
      end
      if (bus.instr_gnt_o) begin
        gq.push_back("I");
        ipend = 1'b0;
      end
      @(posedge clk_i);
      #1;
    end
    chk("starve grant_count", 32'(gq.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      got_g = (i < gq.size()) ? gq[i] : 8'h2D;
      chk($sformatf("starve grant%0d", i), 32'(got_g), 32'(exp_g[i]));
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive({3'b000, bus.mem_req_o, bus.mem_req_o}, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0);
      @(posedge clk_i);
      #1;
    end

    // reset asserted while a fetch sits in WAIT
    apply(mk("rmid_g", 5'b10000, 32'h300, SZ_B, 32'h0, 32'h0, 32'h0, 7'b1000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    apply(mk("rmid_req", 5'b00010, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000010, 32'h0, 32'h0, SZ_W, 32'h300, 32'h0));
    drive(5'b10001, 32'h300, SZ_B, 32'h0, 32'h0, 32'h12345678);
    rst_i = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    apply(mk("post_g", 5'b10000, 32'h400, SZ_B, 32'h0, 32'h0, 32'h0, 7'b1000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));
    apply(mk("post_r", 5'b00011, 32'h0, SZ_B, 32'h0, 32'h0, 32'h00000013, 7'b0100010, 32'h00000013, 32'h0, SZ_W, 32'h400, 32'h0));
    apply(mk("post_idle", 5'b00000, 32'h0, SZ_B, 32'h0, 32'h0, 32'h0, 7'b0000000, 32'h0, 32'h0, SZ_B, 32'h0, 32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its load/store requester. Every data memory access goes through this block.
- Sits between core (instr_* / data_* sides) and the memory (mem_* side).
- One transaction in flight at a time; the memory-side request is registered.
- Data has priority over fetch, with an anti-starvation counter; misaligned data accesses are rejected locally with an error response.

Parameters:
- ADDR_W, 32, address width on all sides.
- STARVE_LIMIT, 4, consecutive data grants allowed while instr_req_i is pending before instr is forced to win.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  ADDR_W  fetch address.
- instr_gnt_o  out  1  fetch request accepted (1-cycle pulse).
- instr_rvalid_o  out  1  fetch data valid (1-cycle pulse).
- instr_rdata_o  out  32  fetch data.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_size_i  in  3  0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU; other codes are illegal.
- data_addr_i  in  ADDR_W  byte address.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  32  load data.
- data_err_o  out  1  qualifies data_rvalid_o: misaligned or illegal size.
- mem_req_o, mem_we_o  out  1  registered memory request / write enable.
- mem_size_o  out  3  registered memory size.
- mem_addr_o  out  ADDR_W  registered memory address.
- mem_wd_o  out  32  registered memory write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response valid (loads and stores).
- mem_rd_i  in  32  memory read data.

Behaviour:
- Reset (rst_i = 0, async):
  - State becomes IDLE, owner becomes INSTR, starve_cnt becomes 0.
  - All outputs are 0.
  - Any in-flight transaction is dropped; memory is reset together with the arbiter.
- Requester rules:
  - Hold req and all attributes stable until the matching gnt.
  - gnt and rvalid never appear in the same cycle for the same requester.
- States: IDLE, REQ, WAIT, ERR.
- IDLE, arbitration (combinational, same cycle):
  - data wins if data_req_i = 1 and not (instr_req_i = 1 and starve_cnt = STARVE_LIMIT); otherwise instr wins if instr_req_i = 1.
  - The winner's gnt_o pulses this cycle, and owner and attributes are captured.
  - If the data winner is misaligned (H/HU with addr[0] = 1; W with addr[1:0] != 0; or size not in {0, 1, 2, 4, 5}): next state ERR, no memory request.
  - Otherwise next state REQ, and mem_* is loaded from the capture (instr: we = 0, size = 2).
  - No request: stay in IDLE, mem_req_o = 0.
- starve_cnt:
  - Increments on a data grant while instr_req_i = 1, saturating at STARVE_LIMIT.
  - Clears on any instr grant, or on a data grant with instr_req_i = 0.
- REQ:
  - mem_req_o = 1; mem_* is held stable until mem_gnt_i.
  - On mem_gnt_i: mem_req_o = 0 next cycle, next state WAIT.
  - If mem_rvalid_i = 1 in the same cycle as mem_gnt_i: complete immediately (response as in WAIT), next state IDLE.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i: owner's rvalid_o = 1 in the same cycle (combinational), and rdata_o = mem_rd_i; next state IDLE.
  - Stores also complete via mem_rvalid_i; data_rdata_o is don't-care for stores.
- ERR: data_rvalid_o = 1 and data_err_o = 1 for one cycle, data_rdata_o = 0; next state IDLE.
- Outputs outside the pulses above:
  - rdata_o is 0 when rvalid_o = 0.
  - data_err_o = 0 except in ERR.
- Minimum latencies:
  - gnt to rvalid is 2 cycles (gnt in IDLE, REQ with immediate mem_gnt_i and mem_rvalid_i).
  - Back-to-back throughput is 1 transaction per 3 cycles (IDLE/REQ/WAIT) with 1-cycle memory.
- mem_rvalid_i in IDLE or ERR is ignored; verification flags it as an assertion.

Decomposition:
- mem_arb_pkg:
  - arb_state_e {IDLE, REQ, WAIT, ERR}.
  - owner_e {INSTR, DATA}.
  - size constants SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5.
- Sub-module mem_align_check (combinational): size and addr[1:0] in, misaligned out. Reused later by the load/store unit.

Test Plan:
- Fetch only: instr_req_i = 1, addr 0x100; mem_gnt_i on first REQ cycle; mem_rvalid_i next cycle with 0x00500093 -> instr_gnt_o in cycle 0, mem_req_o = 1 and mem_addr_o = 0x100 in cycle 1, instr_rvalid_o = 1 and instr_rdata_o = 0x00500093 in cycle 2.
- Simultaneous requests: instr 0x104 and data load W 0x2000 in the same cycle -> data_gnt_o first, mem_addr_o = 0x2000; instr granted only after data_rvalid_o.
- Starvation: data_req_i held with 6 back-to-back loads while instr_req_i = 1, STARVE_LIMIT = 4 -> 4 data grants, then instr_gnt_o, then data resumes.
- Misaligned: data W at 0x2002 -> data_gnt_o, next cycle data_rvalid_o = 1, data_err_o = 1, mem_req_o stays 0. H at 0x2003 behaves the same; H at 0x2002 is forwarded.
- Store with slow memory: SW 0xDEADBEEF to 0x3000, mem_gnt_i delayed 3 cycles -> mem_* stable and mem_req_o = 1 all 3 cycles; mem_we_o = 1, mem_size_o = 2.
- Reset mid-operation: assert rst_i in WAIT -> all outputs 0 immediately; after release, a new fetch proceeds normally from IDLE.
